// File: rtl/usb_pkg.sv
// usb_pkg: shared FSM states, FT245 strobe defaults and SRAM control polarities
package usb_pkg;
  typedef enum logic [3:0] {
    IDLE, SET, RDWAIT, LATCH, TXWAIT, STB_HI, STB_LO, NEXTB, NEXTW
  } state_t;
  localparam int WR_HIGH_DEF = 5;
  localparam int WR_LOW_DEF = 7;
  localparam logic OE_ON = 1'b0;
  localparam logic OE_OFF = 1'b1;
  localparam logic WE_OFF = 1'b1;
endpackage

// File: rtl/ft245_byte_wr.sv
// ft245_byte_wr: one FT245 byte write, WR high WR_HIGH cycles then low WR_LOW cycles with data driven
// Ports: CLK/RST (sync, active-high); go/din start a byte; wr, drv, data go to the FIFO pins;
//   hi_end flags the last WR-high cycle, done flags the last driven WR-low cycle.
module ft245_byte_wr import usb_pkg::*; #(
  parameter int WR_HIGH = WR_HIGH_DEF,
  parameter int WR_LOW = WR_LOW_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       go,
  input  logic [7:0] din,
  output logic       wr,
  output logic       drv,
  output logic [7:0] data,
  output logic       hi_end,
  output logic       done
);
  logic [7:0] cnt;
  // wr doubles as the high-phase flag; drv without wr is the low phase
  assign hi_end = wr && cnt == '0;
  assign done = drv && !wr && cnt == '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr <= 1'b0;
      drv <= 1'b0;
      data <= '0;
      cnt <= '0;
    end else if (go) begin
      wr <= 1'b1;
      drv <= 1'b1;
      data <= din;
      cnt <= 8'(WR_HIGH - 1);
    end else if (hi_end) begin
      wr <= 1'b0;
      cnt <= 8'(WR_LOW - 1);
    end else if (done) begin
      drv <= 1'b0;
    end else if (drv) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/usb_burst_tx.sv
// usb_burst_tx: bursts consecutive 16-bit SRAM words to the FT245 TX FIFO, low byte first
// Ports: CLK/RST (sync, active-high); START/BASE_ADRS/LEN_WORDS request a burst;
//   ADX/CEX/CEY/DX read the SRAM; USBX_O/USB_DRV/WR/TXE drive the FT245;
//   BUSY, DONE (one-cycle pulse) and NEXT_ADRS report progress.
// Build option USB_TXE_TIMEOUT_EN adds parameter TO_CYC and output ERR: a burst
//   stalled by TXE=1 for TO_CYC cycles in TXWAIT aborts with ERR set.
// RD_LAT must be at least 2.
module usb_burst_tx import usb_pkg::*; #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int WR_HIGH = WR_HIGH_DEF,
  parameter int WR_LOW = WR_LOW_DEF,
  parameter int RD_LAT = 2
`ifdef USB_TXE_TIMEOUT_EN
  , parameter int TO_CYC = 65535
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADRS,
  input  logic [7:0]        LEN_WORDS,
  output logic [ADDR_W-1:0] ADX,
  output logic              CEX,
  output logic              CEY,
  input  logic [DATA_W-1:0] DX,
  output logic [7:0]        USBX_O,
  output logic              USB_DRV,
  output logic              WR,
  input  logic              TXE,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] NEXT_ADRS
`ifdef USB_TXE_TIMEOUT_EN
  , output logic            ERR
`endif
);
  state_t state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0] rem, rd_cnt;
  logic [DATA_W-1:0] word;
  logic [7:0] byte_sel;
  logic idx, go, hi_end, bdone, abort, launch, last;
  assign CEY = WE_OFF;
  always_ff @(posedge CLK) state <= RST ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = START && LEN_WORDS != '0 ? SET : IDLE;
      SET:     nxt = RDWAIT;
      RDWAIT:  nxt = rd_cnt == '0 ? LATCH : RDWAIT;
      LATCH:   nxt = TXWAIT;
      TXWAIT:  nxt = abort ? IDLE : !TXE ? STB_HI : TXWAIT;
      STB_HI:  nxt = hi_end ? STB_LO : STB_HI;
      STB_LO:  nxt = !bdone ? STB_LO : idx ? NEXTW : NEXTB;
      NEXTB:   nxt = TXWAIT;
      NEXTW:   nxt = rem == 8'd1 ? IDLE : SET;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    launch = state == IDLE && START;
    go = state == TXWAIT && !TXE;
    last = state == NEXTW && rem == 8'd1;
    byte_sel = idx ? word[15:8] : word[7:0];
  end
`ifdef USB_TXE_TIMEOUT_EN
  logic [31:0] to_cnt;
  assign abort = state == TXWAIT && TXE && to_cnt == 32'(TO_CYC - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
      to_cnt <= '0;
    end else begin
      ERR <= abort || (ERR && !launch);
      to_cnt <= state == TXWAIT && TXE ? to_cnt + 32'd1 : '0;
    end
  end
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr <= '0;
      rem <= '0;
      rd_cnt <= '0;
      word <= '0;
      idx <= 1'b0;
      ADX <= '0;
      CEX <= OE_OFF;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      NEXT_ADRS <= '0;
    end else begin
      DONE <= (launch && LEN_WORDS == '0) || last || abort;
      if (launch) begin
        addr <= BASE_ADRS;
        rem <= LEN_WORDS;
        BUSY <= LEN_WORDS != '0;
        if (LEN_WORDS == '0) NEXT_ADRS <= BASE_ADRS;
      end
      if (state == SET) begin
        ADX <= addr;
        CEX <= OE_ON;
        rd_cnt <= 8'(RD_LAT - 2);
      end
      if (state == RDWAIT) rd_cnt <= rd_cnt - 1'b1;
      if (state == LATCH) begin
        word <= DX;
        idx <= 1'b0;
        CEX <= OE_OFF;
      end
      if (state == NEXTB) idx <= 1'b1;
      if (state == NEXTW) begin
        addr <= addr + 1'b1;
        rem <= rem - 1'b1;
      end
      if (last) begin
        BUSY <= 1'b0;
        NEXT_ADRS <= addr + 1'b1;
      end
      if (abort) begin
        BUSY <= 1'b0;
        NEXT_ADRS <= addr;
      end
    end
  end
  ft245_byte_wr #(.WR_HIGH(WR_HIGH), .WR_LOW(WR_LOW)) u_wr (
    .CLK(CLK),
    .RST(RST),
    .go(go),
    .din(byte_sel),
    .wr(WR),
    .drv(USB_DRV),
    .data(USBX_O),
    .hi_end(hi_end),
    .done(bdone)
  );
endmodule

// File: tb/tb_usb_burst_tx.sv
// tb_usb_burst_tx: directed bench for usb_burst_tx with an SRAM model and FT245 pin monitor
module tb_usb_burst_tx;
  logic CLK = 0, RST = 1, START = 0, TXE = 1;
  logic [19:0] BASE_ADRS = '0, ADX, NEXT_ADRS;
  logic [7:0] LEN_WORDS = '0, USBX_O;
  logic CEX, CEY, USB_DRV, WR, BUSY, DONE;
  logic [15:0] DX;
`ifdef USB_TXE_TIMEOUT_EN
  logic ERR;
`endif
  int total = 0, bad = 0;
  always #4 CLK = ~CLK;
`ifdef USB_TXE_TIMEOUT_EN
  usb_burst_tx #(.TO_CYC(100)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADRS(BASE_ADRS), .LEN_WORDS(LEN_WORDS),
    .ADX(ADX), .CEX(CEX), .CEY(CEY), .DX(DX), .USBX_O(USBX_O), .USB_DRV(USB_DRV),
    .WR(WR), .TXE(TXE), .BUSY(BUSY), .DONE(DONE), .NEXT_ADRS(NEXT_ADRS), .ERR(ERR)
  );
`else
  usb_burst_tx dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADRS(BASE_ADRS), .LEN_WORDS(LEN_WORDS),
    .ADX(ADX), .CEX(CEX), .CEY(CEY), .DX(DX), .USBX_O(USBX_O), .USB_DRV(USB_DRV),
    .WR(WR), .TXE(TXE), .BUSY(BUSY), .DONE(DONE), .NEXT_ADRS(NEXT_ADRS)
  );
`endif
  always_comb DX = CEX ? 16'hDEAD : ADX == 20'h00010 ? 16'h1234 :
                   ADX == 20'h00011 ? 16'hABCD : {~ADX[7:0], ADX[7:0]};
  logic [7:0] bytes_q[$];
  int hi_q[$], lo_q[$];
  logic [19:0] adr_q[$];
  int hi_n = 0, lo_n = 0, done_cyc = 0, wr_edges = 0, cex_edges = 0, drv_edges = 0;
  int wr_rises = 0, cey_low = 0;
  logic p_wr = 0, p_cex = 1, p_drv = 0;
  always @(negedge CLK) begin
    p_wr <= WR;
    p_cex <= CEX;
    p_drv <= USB_DRV;
    hi_n <= WR ? hi_n + 1 : 0;
    lo_n <= (USB_DRV && !WR) ? lo_n + 1 : 0;
    if (p_wr && !WR) begin
      bytes_q.push_back(USBX_O);
      hi_q.push_back(hi_n);
    end
    if (p_drv && !USB_DRV) lo_q.push_back(lo_n);
    if (p_cex && !CEX) adr_q.push_back(ADX);
    if (DONE) done_cyc <= done_cyc + 1;
    if (WR != p_wr) wr_edges <= wr_edges + 1;
    if (WR && !p_wr) wr_rises <= wr_rises + 1;
    if (CEX != p_cex) cex_edges <= cex_edges + 1;
    if (USB_DRV != p_drv) drv_edges <= drv_edges + 1;
    if (!CEY) cey_low <= cey_low + 1;
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic go(logic [19:0] b, logic [7:0] l);
    bytes_q.delete();
    hi_q.delete();
    lo_q.delete();
    adr_q.delete();
    BASE_ADRS = b;
    LEN_WORDS = l;
    START = 1;
    cyc(1);
    START = 0;
  endtask
  task automatic wait_done(string tag, int lim);
    int n = 0;
    while (DONE !== 1'b1 && n < lim) begin
      cyc(1);
      n++;
    end
    chk(tag, DONE, 1);
  endtask
  task automatic wait_latch(string tag, int lim);
    int n = 0;
    while (CEX !== 1'b0 && n < lim) begin
      cyc(1);
      n++;
    end
    while (CEX !== 1'b1 && n < lim) begin
      cyc(1);
      n++;
    end
    chk(tag, n < lim, 1);
  endtask
  task automatic wait_wr(string tag, int lim);
    int n = 0;
    while (WR !== 1'b1 && n < lim) begin
      cyc(1);
      n++;
    end
    chk(tag, WR, 1);
  endtask
  task automatic chk_bytes(string tag, logic [31:0] exp);
    chk({tag, "_n"}, bytes_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_byte"}, bytes_q.size() > i ? bytes_q[i] : 8'hxx, exp[8*i +: 8]);
      chk({tag, "_hi"}, hi_q.size() > i ? hi_q[i] : -1, 5);
      chk({tag, "_lo7"}, lo_q.size() > i ? lo_q[i] >= 7 : 0, 1);
    end
  endtask
  int d0, w0, c0, v0, r0;
  initial begin
    cyc(3);
    chk("rst_adx", ADX, 0);
    chk("rst_cex", CEX, 1);
    chk("rst_cey", CEY, 1);
    chk("rst_usbx", USBX_O, 0);
    chk("rst_drv", USB_DRV, 0);
    chk("rst_wr", WR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_next", NEXT_ADRS, 0);
    RST = 0;
    cyc(2);
    TXE = 0;
    d0 = done_cyc;
    go(20'h00010, 8'd2);
    chk("t1_busy", BUSY, 1);
    cyc(5);
    BASE_ADRS = 20'h00500;
    LEN_WORDS = 8'd9;
    START = 1;
    cyc(1);
    START = 0;
    wait_done("t1_done", 200);
    cyc(3);
    chk_bytes("t1", 32'hABCD1234);
    chk("t1_adr_n", adr_q.size(), 2);
    chk("t1_adr0", adr_q.size() > 0 ? adr_q[0] : 20'hxxxxx, 20'h00010);
    chk("t1_adr1", adr_q.size() > 1 ? adr_q[1] : 20'hxxxxx, 20'h00011);
    chk("t1_done_once", done_cyc - d0, 1);
    chk("t1_next", NEXT_ADRS, 20'h00012);
    chk("t1_busy_end", BUSY, 0);
    w0 = wr_edges;
    c0 = cex_edges;
    v0 = drv_edges;
    go(20'h00020, 8'd0);
    chk("t2_done", DONE, 1);
    chk("t2_busy", BUSY, 0);
    cyc(1);
    chk("t2_done_end", DONE, 0);
    cyc(20);
    chk("t2_wr", wr_edges - w0, 0);
    chk("t2_cex", cex_edges - c0, 0);
    chk("t2_drv", drv_edges - v0, 0);
    TXE = 1;
    go(20'h00010, 8'd1);
    wait_latch("t3_latch", 50);
    w0 = wr_edges;
    cyc(40);
    chk("t3_stall_wr", wr_edges - w0, 0);
    chk("t3_stall_lvl", WR, 0);
    TXE = 0;
    wait_wr("t3_wr_start", 20);
    cyc(2);
    TXE = 1;
    cyc(15);
    chk("t3_n1", bytes_q.size(), 1);
    chk("t3_b0", bytes_q.size() > 0 ? bytes_q[0] : 8'hxx, 8'h34);
    chk("t3_hi0", hi_q.size() > 0 ? hi_q[0] : -1, 5);
    chk("t3_wait2", WR, 0);
    cyc(10);
    TXE = 0;
    wait_done("t3_done", 100);
    cyc(2);
    chk("t3_n2", bytes_q.size(), 2);
    chk("t3_b1", bytes_q.size() > 1 ? bytes_q[1] : 8'hxx, 8'h12);
    chk("t3_hi1", hi_q.size() > 1 ? hi_q[1] : -1, 5);
    go(20'hFFFFF, 8'd2);
    wait_done("t4_done", 200);
    cyc(3);
    chk_bytes("t4", 32'hFF0000FF);
    chk("t4_adr0", adr_q.size() > 0 ? adr_q[0] : 20'hxxxxx, 20'hFFFFF);
    chk("t4_adr1", adr_q.size() > 1 ? adr_q[1] : 20'hxxxxx, 20'h00000);
    chk("t4_next", NEXT_ADRS, 20'h00001);
    r0 = wr_rises;
    d0 = done_cyc;
    go(20'h00010, 8'd2);
    for (int n = 0; n < 100 && wr_rises - r0 < 2; n++) cyc(1);
    chk("t5_second_strobe", WR, 1);
    RST = 1;
    cyc(1);
    RST = 0;
    chk("t5_wr", WR, 0);
    chk("t5_drv", USB_DRV, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_cex", CEX, 1);
    chk("t5_done", DONE, 0);
    cyc(30);
    chk("t5_no_done", done_cyc - d0, 0);
    RST = 1;
    START = 1;
    LEN_WORDS = 8'd0;
    cyc(1);
    RST = 0;
    START = 0;
    chk("t5_rst_wins", DONE, 0);
    cyc(2);
    go(20'h00010, 8'd2);
    wait_done("t5_clean_done", 200);
    cyc(3);
    chk_bytes("t5", 32'hABCD1234);
    chk("t5_next", NEXT_ADRS, 20'h00012);
`ifdef USB_TXE_TIMEOUT_EN
    TXE = 1;
    go(20'h00040, 8'd1);
    wait_latch("t6_latch", 50);
    cyc(99);
    chk("t6_err_early", ERR, 0);
    chk("t6_done_early", DONE, 0);
    cyc(1);
    chk("t6_err", ERR, 1);
    chk("t6_done", DONE, 1);
    chk("t6_busy", BUSY, 0);
    chk("t6_next", NEXT_ADRS, 20'h00040);
    cyc(1);
    chk("t6_err_hold", ERR, 1);
    TXE = 0;
    go(20'h00010, 8'd1);
    chk("t6_err_clr", ERR, 0);
    wait_done("t6_clean_done", 100);
`endif
    chk("cey_high", cey_low, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
